// File: rtl/fir_decim_avg_if.sv
// fir_decim_avg_if: sample/result bundle between the FIR stage,
// the decimating averager and the downstream readout logic.
interface fir_decim_avg_if #(
    parameter int WIDTH = 32
) ();
    logic                    i_en;
    logic                    i_trig;
    logic [3:0]              i_dec_log2;
    logic signed [WIDTH-1:0] din;
    logic signed [WIDTH-1:0] dout;
    logic                    o_valid;
    logic                    o_busy;

    modport master (
        output i_en,
        output i_trig,
        output i_dec_log2,
        output din,
        input  dout,
        input  o_valid,
        input  o_busy
    );

    modport slave (
        input  i_en,
        input  i_trig,
        input  i_dec_log2,
        input  din,
        output dout,
        output o_valid,
        output o_busy
    );
endinterface

// File: rtl/fir_decim_avg.sv
// fir_decim_avg: averages 2^k FIR outputs per window and emits one
// round-half-up average with a single-cycle valid strobe.
module fir_decim_avg #(
    parameter int WIDTH    = 32,
    parameter int MAX_LOG2 = 8,
    parameter int ACC_W    = WIDTH + MAX_LOG2,
    parameter int TRIG_DLY = 3
) (
    input logic             clk,
    input logic             rst,
    fir_decim_avg_if.slave  bus
);
    localparam int         CW   = MAX_LOG2 + 1;
    localparam logic [3:0] MAXD = 4'(MAX_LOG2);

    typedef enum logic [0:0] {
        S_IDLE,
        S_ACCUM
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [CW-1:0]           r_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [3:0]              r_dec;
    logic [3:0]              w_dec_nxt;
    logic signed [ACC_W-1:0] r_sum;
    logic signed [ACC_W-1:0] w_sum_nxt;
    logic                    r_sum_vld;
    logic                    w_sum_vld_nxt;
    logic [3:0]              r_shift;
    logic [3:0]              w_shift_nxt;
    logic signed [WIDTH-1:0] r_dout;
    logic                    r_valid;

    logic                    w_trig_d;
    logic [3:0]              w_dec_clamp;
    logic signed [ACC_W-1:0] w_din_x;
    logic signed [ACC_W-1:0] w_acc_add;
    logic [CW-1:0]           w_cnt_inc;
    logic [CW-1:0]           w_win;
    logic                    w_last;
    logic signed [ACC_W-1:0] w_round;
    logic signed [ACC_W-1:0] w_sum_rnd;
    logic signed [ACC_W-1:0] w_shr;
    logic signed [WIDTH-1:0] w_avg;

    generate
        if (TRIG_DLY == 0) begin : g_nodly
            assign w_trig_d = bus.i_trig;
        end else begin : g_dly
            logic [TRIG_DLY-1:0] r_trig_sr;

            // Delay the FIR input strobe to line up with its filtered output
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_trig_sr <= '0;
                end else begin
                    r_trig_sr[0] <= bus.i_trig;
                    for (int i = 1; i < TRIG_DLY; i++) begin
                        r_trig_sr[i] <= r_trig_sr[i-1];
                    end
                end
            end

            assign w_trig_d = r_trig_sr[TRIG_DLY-1];
        end
    endgenerate

    assign w_dec_clamp = (bus.i_dec_log2 > MAXD) ? MAXD : bus.i_dec_log2;
    assign w_din_x     = {{(ACC_W-WIDTH){bus.din[WIDTH-1]}}, bus.din};
    assign w_acc_add   = r_acc + w_din_x;
    assign w_cnt_inc   = r_cnt + CW'(1);
    assign w_win       = CW'(1) << r_dec;
    assign w_last      = (w_cnt_inc == w_win);

    // State register plus accumulator/window bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_dec     <= '0;
            r_sum     <= '0;
            r_sum_vld <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dec     <= w_dec_nxt;
            r_sum     <= w_sum_nxt;
            r_sum_vld <= w_sum_vld_nxt;
            r_shift   <= w_shift_nxt;
        end
    end

    // Next state: accumulate on delayed trigger, close window at 2^dec
    always_comb begin
        w_state_nxt   = r_state;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_dec_nxt     = r_dec;
        w_sum_nxt     = r_sum;
        w_sum_vld_nxt = 1'b0;
        w_shift_nxt   = r_shift;
        unique case (r_state)
            S_IDLE: begin
                w_acc_nxt = '0;
                w_cnt_nxt = '0;
                if (bus.i_en) begin
                    w_dec_nxt   = w_dec_clamp;
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_trig_d) begin
                    if (w_last) begin
                        w_sum_nxt     = w_acc_add;
                        w_sum_vld_nxt = 1'b1;
                        w_shift_nxt   = r_dec;
                        w_acc_nxt     = '0;
                        w_cnt_nxt     = '0;
                        w_dec_nxt     = w_dec_clamp;
                    end else begin
                        w_acc_nxt = w_acc_add;
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                if (!bus.i_en) begin
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_round   = (r_shift == 4'd0) ? '0
                     : (ACC_W'(1) << (r_shift - 4'd1));
    assign w_sum_rnd = r_sum + w_round;
    assign w_shr     = w_sum_rnd >>> r_shift;
    assign w_avg     = WIDTH'(w_shr);

    // Output stage: rounded average, held until the next window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= r_sum_vld;
            if (r_sum_vld) begin
                r_dout <= w_avg;
            end
        end
    end

    assign bus.dout    = r_dout;
    assign bus.o_valid = r_valid;
    assign bus.o_busy  = (r_state == S_ACCUM);

endmodule

// File: doc/fir_decim_avg.md
Name: fir_decim_avg

Overview:
- Post-FIR decimating averager for the ADC channel. Sits directly downstream of the gated FIR stage and consumes its 32-bit signed filtered output.
- Averages 2^k filtered samples per output. k is selectable at run time. The FIR's `i_trig` strobe is delayed by the FIR pipeline latency so that each sample is taken when the matching filtered value is valid.
- Produces one rounded average plus a one-cycle valid strobe per window. The result feeds the downstream demodulation/readout logic.

Parameters:
- WIDTH, 32: input/output sample width (signed).
- MAX_LOG2, 8: maximum log2 of the decimation ratio (max 256 samples per window).
- ACC_W, WIDTH+MAX_LOG2 (40): accumulator width.
- TRIG_DLY, 3: clk cycles from `i_trig` to a valid matching `din`. 0 means `i_trig` is used directly.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  averager enable. Low means idle and the partial window is discarded.
- i_trig  in  1  sample strobe; the same strobe that drives the FIR input latch.
- i_dec_log2  in  4  requested log2 of the decimation ratio. Values above MAX_LOG2 are clamped.
- din  in  WIDTH  signed filtered sample from the FIR stage.
- dout  out  WIDTH  signed rounded window average. Holds its value between updates.
- o_valid  out  1  one-cycle pulse marking a new `dout`.
- o_busy  out  1  high while in ACCUM state.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge). All of the following are cleared:
  - `dout`=0, `o_valid`=0, `o_busy`=0.
  - state=IDLE, acc=0, cnt=0.
  - trig delay line all 0, result pipeline register and its valid flag 0.
  - rst has priority over every other input. A reset mid-window discards the window; no `o_valid` is produced for it.
- Trigger alignment: `trig_d` is `i_trig` passed through a TRIG_DLY-stage shift register. `din` is sampled only in cycles where `trig_d`=1.
- State machine:
  - IDLE: acc=0, cnt=0, `o_busy`=0. When `i_en`=1: latch dec_r = min(`i_dec_log2`, MAX_LOG2), go to ACCUM. A `trig_d` in the same cycle as the IDLE→ACCUM transition is ignored.
  - ACCUM: `o_busy`=1. On `trig_d`:
    - If cnt+1 < 2^dec_r: acc <= acc + sext(`din`), cnt <= cnt+1.
    - If cnt+1 == 2^dec_r (window complete):
      - sum_r <= acc + sext(`din`), and the sum's valid flag is set.
      - Latch shift_r <= dec_r.
      - acc <= 0, cnt <= 0.
      - Reload dec_r from clamped `i_dec_log2`.
      - Stay in ACCUM.
  - ACCUM with `i_en`=0: go to IDLE. acc and cnt are cleared. A window that completed in that same cycle is still output.
- `i_dec_log2` changes take effect only at window boundaries (or on IDLE→ACCUM). A change mid-window does not alter the current window.
- No dead cycle between windows: `trig_d` every cycle with dec_r=0 yields one output per cycle, and no sample is lost.
- Output stage, one cycle after sum_r is loaded:
  - `dout` <= (sum_r + round) >>> shift_r, where round = 0 if shift_r=0, else 2^(shift_r-1). This is round-half-up, arithmetic shift (floor).
  - `o_valid` <= 1 for exactly one cycle.
  - The result always fits in WIDTH; no saturation is required.
- Latency: `trig_d` of the completing sample at edge t → sum_r at t+1 → `dout`/`o_valid` visible after edge t+2. Measured from `i_trig`: TRIG_DLY+2 cycles.
- Arithmetic:
  - Sign-extend `din` to ACC_W.
  - cnt is MAX_LOG2+1 bits wide.
  - acc never overflows: at most 2^MAX_LOG2 samples of WIDTH bits.
- `dout` holds its last value when `o_valid`=0, in IDLE, and across `i_en` toggles. Only rst clears it.

Test Plan:
- TRIG_DLY=0, `i_dec_log2`=2, `din`=100, 4 triggers spaced 5 clk apart → one `o_valid` pulse 2 cycles after the 4th trigger, `dout`=100; no other pulses.
- `i_dec_log2`=2, samples 1,2,3,5 → `dout`=3 ((11+2)>>>2). Samples -1,-2,-3,-5 → `dout`=-3 ((-11+2)>>>2).
- `i_dec_log2`=0, `i_trig` held high 6 cycles, `din`=10,11,...,15 → 6 consecutive `o_valid` cycles, `dout`=10..15, each 2 cycles after its sample.
- TRIG_DLY=3: `i_trig` pulse at cycle 10, `din`=7 only at cycle 13 (0 elsewhere), `i_dec_log2`=0 → `dout`=7 with `o_valid` at cycle 15.
- `i_en` dropped after 2 of 4 samples, re-raised, then 4 samples of 50 → no pulse for the partial window; next output `dout`=50. rst asserted mid-window → all outputs 0; the next window is uncontaminated.
- `i_dec_log2` changed 2→3 after the 1st sample of a window → that window closes after 4 samples, the next after 8. `i_dec_log2`=15 → window of 256 samples.
